// File: rtl/track_store_aging.sv
// -----------------------------------------------------------------------------
// track_store_aging
//
// Track database for the fusion pipeline. A single command port carries
// READ / ALLOC / UPDATE / DELETE. ALLOC picks the lowest free slot. Every slot
// carries a last-touched timestamp, and a background sweep evicts slots whose
// age reaches the configured timeout, one slot per idle cycle.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd_valid/ready     command handshake (accepted when both high)
//   cmd_op              0=READ 1=ALLOC 2=UPDATE 3=DELETE
//   cmd_id              target slot (ignored for ALLOC)
//   cmd_data            record for ALLOC / UPDATE
//   rsp_valid           one-cycle response pulse
//   rsp_status          0=OK 1=NOT_FOUND 2=FULL
//   rsp_id              slot operated on (assigned slot for ALLOC)
//   rsp_data            READ data, 0 otherwise
//   now_ms              free-running time in ms (wraps modulo 2^TS_W)
//   cfg_timeout_ms      age limit, 0 disables aging
//   cfg_age_en          aging enable
//   evict_valid/id      one-cycle pulse per aged-out slot
//   active_count        number of valid slots
//   db_full, db_empty   active_count == MAX_TRACKS / == 0
//
// Command latency: accept at edge T, FSM in EXEC after T, RESP after T+1,
// registered response (and cmd_ready) visible after T+2.
// -----------------------------------------------------------------------------
module track_store_aging #(
    parameter int MAX_TRACKS = 1024,
    parameter int ID_W       = $clog2(MAX_TRACKS),
    parameter int DATA_W     = 512,
    parameter int TS_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ID_W-1:0]   cmd_id,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [1:0]        rsp_status,
    output logic [ID_W-1:0]   rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    input  logic [TS_W-1:0]   now_ms,
    input  logic [TS_W-1:0]   cfg_timeout_ms,
    input  logic              cfg_age_en,
    output logic              evict_valid,
    output logic [ID_W-1:0]   evict_id,
    output logic [ID_W:0]     active_count,
    output logic              db_full,
    output logic              db_empty
);

    localparam logic [ID_W:0] MAX_CNT  = (ID_W+1)'(MAX_TRACKS);
    localparam logic [ID_W:0] CNT_ONE  = (ID_W+1)'(1);
    localparam logic [ID_W-1:0] ID_ONE = ID_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;
    typedef enum logic [1:0] {
        OP_READ   = 2'd0,
        OP_ALLOC  = 2'd1,
        OP_UPDATE = 2'd2,
        OP_DELETE = 2'd3
    } op_e;
    typedef enum logic [1:0] {
        RSP_OK        = 2'd0,
        RSP_NOT_FOUND = 2'd1,
        RSP_FULL      = 2'd2
    } status_e;

    // Control state
    state_e                state_q, state_d;
    op_e                   op_q, op_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [DATA_W-1:0]     data_q, data_d;
    status_e               status_q, status_d;
    logic [MAX_TRACKS-1:0] valid_q, valid_d;
    logic [ID_W:0]         count_q, count_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;

    // Registered outputs
    logic                  evict_valid_q, evict_valid_d;
    logic [ID_W-1:0]       evict_id_q, evict_id_d;
    logic                  rsp_valid_q, rsp_valid_d;
    status_e               rsp_status_q, rsp_status_d;
    logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]     rsp_data_q, rsp_data_d;

    // Record RAM and timestamp array share one address per cycle
    logic [DATA_W-1:0]     rec_mem [MAX_TRACKS];
    logic [TS_W-1:0]       ts_mem  [MAX_TRACKS];
    logic [DATA_W-1:0]     rd_data_q;
    logic                  rec_we;
    logic                  ts_we;
    logic [ID_W-1:0]       mem_addr;

    // Derived combinational terms
    logic                  free_found;
    logic [ID_W-1:0]       free_id;
    logic                  id_hit;
    logic                  sweep_en;
    logic [TS_W-1:0]       age;
    logic                  expire;
    logic                  ptr_last;

    // Lowest clear bit of the bitmap. Scanning downward lets the last hit win.
    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        free_found = 1'b0;
        free_id    = '0;
        for (int i = MAX_TRACKS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_id    = ID_W'(i);
            end
        end
    end

    // Out-of-range IDs (possible when MAX_TRACKS is not a power of two) never hit.
    assign id_hit = ({1'b0, id_q} < MAX_CNT) && valid_q[id_q];

    // Sweep only in true idle cycles, so it can never race a command on the bitmap.
    assign sweep_en = (state_q == S_IDLE) && !cmd_valid && cfg_age_en
                      && (cfg_timeout_ms != '0);
    // Modular subtraction keeps the age correct across now_ms wrap.
    assign age      = now_ms - ts_mem[ptr_q];
    assign expire   = sweep_en && valid_q[ptr_q] && (age >= cfg_timeout_ms);
    assign ptr_last = ({1'b0, ptr_q} == (MAX_CNT - CNT_ONE));

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        id_d          = id_q;
        data_d        = data_q;
        status_d      = status_q;
        valid_d       = valid_q;
        count_d       = count_q;
        ptr_d         = ptr_q;
        evict_valid_d = 1'b0;
        evict_id_d    = evict_id_q;
        rsp_valid_d   = 1'b0;
        rsp_status_d  = RSP_OK;
        rsp_id_d      = '0;
        rsp_data_d    = '0;
        rec_we        = 1'b0;
        ts_we         = 1'b0;
        mem_addr      = id_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = op_e'(cmd_op);
                    id_d    = cmd_id;
                    data_d  = cmd_data;
                    state_d = S_EXEC;
                end else if (sweep_en) begin
                    ptr_d = ptr_last ? '0 : ptr_q + ID_ONE;
                    if (expire) begin
                        valid_d[ptr_q] = 1'b0;
                        count_d        = count_q - CNT_ONE;
                        evict_valid_d  = 1'b1;
                        evict_id_d     = ptr_q;
                    end
                end
            end

            S_EXEC: begin
                state_d  = S_RESP;
                status_d = RSP_OK;
                unique case (op_q)
                    OP_READ: begin
                        // RAM read is issued unconditionally; a miss masks rsp_data later.
                        if (!id_hit) status_d = RSP_NOT_FOUND;
                    end
                    OP_ALLOC: begin
                        if (free_found) begin
                            mem_addr         = free_id;
                            rec_we           = 1'b1;
                            ts_we            = 1'b1;
                            valid_d[free_id] = 1'b1;
                            count_d          = count_q + CNT_ONE;
                            id_d             = free_id;
                        end else begin
                            status_d = RSP_FULL;
                            id_d     = '0;
                        end
                    end
                    OP_UPDATE: begin
                        if (id_hit) begin
                            rec_we = 1'b1;
                            ts_we  = 1'b1;
                        end else begin
                            status_d = RSP_NOT_FOUND;
                        end
                    end
                    OP_DELETE: begin
                        if (id_hit) begin
                            valid_d[id_q] = 1'b0;
                            count_d       = count_q - CNT_ONE;
                        end else begin
                            status_d = RSP_NOT_FOUND;
                        end
                    end
                    default: status_d = RSP_NOT_FOUND;
                endcase
            end

            S_RESP: begin
                state_d      = S_IDLE;
                rsp_valid_d  = 1'b1;
                rsp_status_d = status_q;
                rsp_id_d     = id_q;
                if (op_q == OP_READ && status_q == RSP_OK) rsp_data_d = rd_data_q;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            op_q          <= OP_READ;
            id_q          <= '0;
            status_q      <= RSP_OK;
            valid_q       <= '0;
            count_q       <= '0;
            ptr_q         <= '0;
            evict_valid_q <= 1'b0;
            evict_id_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_status_q  <= RSP_OK;
            rsp_id_q      <= '0;
            rsp_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            id_q          <= id_d;
            status_q      <= status_d;
            valid_q       <= valid_d;
            count_q       <= count_d;
            ptr_q         <= ptr_d;
            evict_valid_q <= evict_valid_d;
            evict_id_q    <= evict_id_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_status_q  <= rsp_status_d;
            rsp_id_q      <= rsp_id_d;
            rsp_data_q    <= rsp_data_d;
        end
    end

    // NOTE: storage arrays and the latched payload carry no reset so they map onto block RAM / plain flops.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        if (rec_we) rec_mem[mem_addr] <= data_q;
        if (ts_we)  ts_mem[mem_addr]  <= now_ms;
        rd_data_q <= rec_mem[mem_addr];
    end

    assign cmd_ready    = (state_q == S_IDLE);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_status   = rsp_status_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_data     = rsp_data_q;
    assign evict_valid  = evict_valid_q;
    assign evict_id     = evict_id_q;
    assign active_count = count_q;
    assign db_full      = (count_q == MAX_CNT);
    assign db_empty     = (count_q == '0);

endmodule

// File: doc/track_store_aging.md
Name: track_store_aging

Overview:
Second-generation track database for the fusion pipeline. It replaces the externally-managed store with a single command port carrying READ, ALLOC, UPDATE and DELETE operations. ALLOC assigns the lowest free track ID automatically. Each entry carries a timestamp, and a background aging sweep evicts stale tracks autonomously. It sits between the association engine and the track manager; evictions are reported on a dedicated pulse interface.

Parameters:
MAX_TRACKS, 1024, number of track slots (any value ≥2; need not be a power of 2)
ID_W, $clog2(MAX_TRACKS), track ID width
DATA_W, 512, track record width (block-RAM inferred)
TS_W, 32, timestamp width in ms (modular)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when valid&&ready
cmd_op  in  2  0=READ 1=ALLOC 2=UPDATE 3=DELETE
cmd_id  in  ID_W  target ID (ignored for ALLOC)
cmd_data  in  DATA_W  record for ALLOC/UPDATE
rsp_valid  out  1  one-cycle response pulse
rsp_status  out  2  0=OK 1=NOT_FOUND 2=FULL
rsp_id  out  ID_W  ID operated on (assigned ID for ALLOC)
rsp_data  out  DATA_W  READ data; 0 otherwise
now_ms  in  TS_W  current time
cfg_timeout_ms  in  TS_W  age limit; 0 disables aging
cfg_age_en  in  1  aging enable
evict_valid  out  1  one-cycle pulse per aged-out track
evict_id  out  ID_W  evicted ID
active_count  out  ID_W+1  valid entries
db_full  out  1  active_count==MAX_TRACKS
db_empty  out  1  active_count==0

Behaviour:
- Reset: all outputs 0 except cmd_ready=1 and db_empty=1.
  - Reset clears the valid bitmap, active_count, sweep pointer and FSM.
  - RAM contents are not cleared.
  - Reset mid-command drops the command with no response.
- FSM states:
  - IDLE: cmd_ready=1. On accept, latch op/id/data and go to EXEC.
  - EXEC: check bitmap; issue RAM read or write; go to RESP.
  - RESP: rsp_valid=1; return to IDLE.
- Timing: command accepted at edge T gives rsp_valid high in the cycle after edge T+2. cmd_ready is high again in that same cycle. One command is outstanding at a time; the maximum rate is one command per 3 cycles.
- READ:
  - Valid ID: rsp_data = stored record, status OK.
  - Otherwise: NOT_FOUND, rsp_data=0.
  - Timestamp is not refreshed.
- ALLOC:
  - Priority-encode the lowest clear bitmap bit; write cmd_data; set the bit; stamp ts=now_ms sampled in EXEC; count+1; status OK with rsp_id set.
  - If full: status FULL, rsp_id=0, no write.
- UPDATE:
  - Valid ID: write the record, refresh ts=now_ms, status OK.
  - Otherwise: NOT_FOUND, no write.
- DELETE:
  - Valid ID: clear the bit, count-1, status OK.
  - Otherwise: NOT_FOUND.
- cmd_id ≥ MAX_TRACKS returns NOT_FOUND for READ, UPDATE and DELETE.
- Timestamps are held in a separate TS_W×MAX_TRACKS array.
- Aging sweep:
  - Runs one slot per cycle, only when FSM=IDLE, cmd_valid=0, cfg_age_en=1 and cfg_timeout_ms≠0. Otherwise the pointer holds.
  - Expiry test: slot valid and (now_ms − ts[ptr]) mod 2^TS_W ≥ cfg_timeout_ms, using unsigned TS_W-bit subtraction.
  - On expiry: clear the bit, count-1, and pulse evict_valid/evict_id in the next cycle.
  - The pointer wraps from MAX_TRACKS−1 to 0.
- Commands have priority over the sweep. Because the sweep never runs while a command is in flight, a swept slot never conflicts with a command.
- active_count is a registered up/down counter (no popcount). Two updates in one cycle are impossible by construction.
- db_full and db_empty are combinational from active_count.

Test Plan:
1. Reset, then ALLOC ×3 with data A,B,C → rsp_id 0,1,2, status OK, active_count=3; each rsp_valid lands exactly 2 cycles after accept.
2. DELETE id1 → OK. ALLOC D → rsp_id=1. READ id1 → rsp_data=D. UPDATE id7 (never allocated) → NOT_FOUND, count unchanged.
3. MAX_TRACKS=6 (non power of 2): 6 ALLOCs → db_full=1. 7th ALLOC → FULL, rsp_id=0. READ id6 → NOT_FOUND.
4. Aging with timeout=100: ALLOC at now=0 (id0) and now=50 (id1); idle at now=120 → single evict id0; now=150 → evict id1; active_count=0, db_empty=1.
5. Wrap with timeout=0x40: ALLOC at now=0xFFFFFFF0; now=0x20 → no eviction; now=0x30 → eviction.
6. Hold cmd_valid continuously through an expiry window → no evict_valid until cmd_valid drops. Assert rst_n low during EXEC → no rsp_valid, count=0, cmd_ready=1 after release.
